// File: rtl/tail_emitter_pkg.sv
// rtl/tail_emitter_pkg.sv - shared state, length-code and size constants for tail_emitter
package tail_emitter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HEAD,
      TAIL
   } state_t;

   localparam logic [3:0] LEN_BAD = 4'd0;
   localparam logic [3:0] LEN_1   = 4'd1;
   localparam logic [3:0] LEN_2   = 4'd2;
   localparam logic [3:0] LEN_4   = 4'd4;
   localparam logic [3:0] LEN_8   = 4'd8;

   localparam int MAX_TAIL = 7;

endpackage

// File: rtl/tail_emitter_hdr_len_enc.sv
// rtl/tail_emitter_hdr_len_enc.sv - header nibble to (legal, len-1); same table as the fetch-side decoder
module hdr_len_enc
   import tail_emitter_pkg::*;
(
   input  logic [3:0] hdr,
   output logic       legal,
   output logic [2:0] len_m1
);

   logic [3:0] len;

   always_comb begin
      len = LEN_BAD;
      if (hdr[1:0] == 2'b00)
         len = LEN_1;
      else if (hdr[3] && !hdr[1])
         len = LEN_1;
      else if (hdr == 4'b0001)
         len = LEN_2;
      else if (hdr == 4'b0010)
         len = LEN_4;
      else if (hdr == 4'b0011)
         len = LEN_8;
   end

   assign legal  = (len != LEN_BAD);
   // LEN_8 - 1 = 7 fits exactly; the wrapped value for LEN_BAD is never latched
   assign len_m1 = 3'(len - 4'd1);

endmodule

// File: rtl/tail_emitter.sv
// rtl/tail_emitter.sv - serializes header + tail units onto a valid/ready unit stream
// Optional TAIL_EMITTER_ERR_CNT_EN adds a saturating rejected-header counter (err_cnt, err_clr).
module tail_emitter #(
   parameter int UNIT_W   = 4,
   parameter int MAX_TAIL = tail_emitter_pkg::MAX_TAIL
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_hdr,
   input  logic [UNIT_W*MAX_TAIL-1:0] in_tail,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [UNIT_W-1:0]          out_data,
   output logic                       out_last,
   output logic                       err_pulse
`ifdef TAIL_EMITTER_ERR_CNT_EN
   ,
   output logic [7:0]                 err_cnt,
   input  logic                       err_clr
`endif
);

   import tail_emitter_pkg::*;

   state_t                     state, state_nx;
   logic [3:0]                 hdr_q;
   logic [UNIT_W*MAX_TAIL-1:0] tail_q;
   logic [2:0]                 cnt;
   logic [2:0]                 idx;
   logic                       legal;
   logic [2:0]                 len_m1;
   logic                       out_hs, pkt_done, in_hs, accept, reject;

   hdr_len_enc u_enc (
      .hdr    (in_hdr),
      .legal  (legal),
      .len_m1 (len_m1)
   );

   always_comb begin
      out_data = '0;
      out_last = 1'b0;
      case (state)
         HEAD: begin
            out_data = UNIT_W'(hdr_q);
            out_last = (cnt == 3'd0);
         end
         TAIL: begin
            out_data = tail_q[int'(idx)*UNIT_W +: UNIT_W];
            out_last = (cnt == 3'd1);
         end
         default: ;
      endcase
   end

   assign out_valid = (state != IDLE);
   assign out_hs    = out_valid && out_ready;
   assign pkt_done  = out_hs && out_last;
   // Accepting during the last unit's handshake keeps packets back-to-back
   assign in_ready  = (state == IDLE) || pkt_done;
   assign in_hs     = in_valid && in_ready;
   assign accept    = in_hs && legal;
   assign reject    = in_hs && !legal;

   always_comb begin
      state_nx = state;
      if (accept)
         state_nx = HEAD;
      else if (pkt_done)
         state_nx = IDLE;
      else if (state == HEAD && out_hs)
         state_nx = TAIL;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdr_q     <= '0;
         tail_q    <= '0;
         cnt       <= '0;
         idx       <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= reject;
         if (accept) begin
            hdr_q  <= in_hdr;
            tail_q <= in_tail;
            cnt    <= len_m1;
            idx    <= '0;
         end else if (state == TAIL && out_hs) begin
            idx <= idx + 3'd1;
            cnt <= cnt - 3'd1;
         end
      end
   end

`ifdef TAIL_EMITTER_ERR_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (reject && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule
